pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised, handshaked pipeline stage register with a two-entry skid buffer, synchronous flush to a programmable bubble value, an external hold, and a saturating stall counter. It replaces the fixed-width 64-bit IF/ID-style latch between any two stages of the pipelined CPU, such as IF/ID, ID/EX, EX/MEM and MEM/WB. It sustains one transfer per cycle under back-pressure without a combinational ready path from downstream to upstream.

## Interface
- DATA_W, 64, width of the payload carried through the stage (e.g. PC+4 concatenated with the instruction).
- FLUSH_VAL, {DATA_W{1'b0}}, value driven on out_data whenever the stage holds no valid entry (bubble/NOP).
- CNT_W, 16, width of the stall counter.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  upstream presents a beat.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage presents a beat downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload to the next stage.
- flush  in  1  synchronous kill of all stored and incoming beats.
- hold  in  1  freezes the stage: no accept, no release.
- occupancy  out  2  number of stored entries (0–2).
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles.

## Operation
- Storage: main register (main_valid, main_data) drives the outputs; skid register (skid_valid, skid_data) is internal.
- in_ready = ~skid_valid & ~hold. out_valid = main_valid & ~hold. out_data = main_valid ? main_data : FLUSH_VAL.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- States are encoded by {skid_valid, main_valid}: EMPTY (00), ONE (01), FULL (11). The encoding 10 is illegal and never reached.
- EMPTY: in_fire goes to ONE with main ← in_data.
- ONE:
  - in_fire & out_fire stays in ONE with main ← in_data.
  - in_fire only goes to FULL with skid ← in_data.
  - out_fire only goes to EMPTY.
  - No event stays in ONE.
- FULL: in_ready = 0, so in_fire cannot occur. out_fire goes to ONE with main ← skid. No event stays in FULL.
- flush (highest priority): on the next edge go to EMPTY, both valids 0, main_data ← FLUSH_VAL. A beat accepted in the same cycle (in_fire) is discarded. An out_fire in the same cycle still completes downstream.
- hold forces in_ready and out_valid low, so no transfer occurs and state is unchanged. flush overrides hold.
- occupancy = main_valid + skid_valid.
- stall_cnt increments by 1 in every cycle with main_valid & ~out_ready & ~hold. It saturates at 2^CNT_W−1 and is cleared only by reset; flush does not clear it.
- Order is preserved: no beat is duplicated or reordered.

## Timing
- Reset values: main_valid = 0, skid_valid = 0, main_data = FLUSH_VAL, skid_data = 0, out_valid = 0, out_data = FLUSH_VAL, in_ready = 1 (with hold = 0), occupancy = 0, stall_cnt = 0.
- Reset asserted mid-operation clears everything asynchronously. The first accept is possible on the first rising edge after deassertion.
- Latency: in_fire at edge N makes the beat visible on out_data/out_valid after edge N (one cycle).
- Throughput: 1 beat/cycle with out_ready held high. Occupancy stays ≤ 1 in that case.
- in_ready depends only on registered skid_valid and the hold input, with no path from out_ready.
- out_valid/out_data depend only on registers and hold.
- Back-pressure: after out_ready drops, at most one further beat is absorbed (into skid) before in_ready falls.

## Test plan
- **Streaming.** Reset, then in_valid = 1 with data 1,2,3,4 on consecutive cycles and out_ready = 1.
  - Required: out_data 1,2,3,4 one cycle later, occupancy ≤ 1, stall_cnt = 0.
- **Back-pressure.** Send 0xA, 0xB, 0xC with out_ready = 0.
  - Required: 0xA in main, 0xB in skid, in_ready = 0 with 0xC held; occupancy = 2; stall_cnt increments every cycle.
  - Then raise out_ready. Required: out_data 0xA, 0xB, 0xC in order, with no gaps after 0xA.
- **Flush.** Reach FULL, then pulse flush with in_valid = 1.
  - Required next cycle: occupancy = 0, out_valid = 0, out_data = FLUSH_VAL, and the incoming beat is never output.
  - Also test flush together with hold = 1. Required: the same result.
- **Hold.** Reach ONE with 0x5, then hold = 1 for 3 cycles with in_valid = 1.
  - Required: in_ready = 0, out_valid = 0, no state change, stall_cnt unchanged.
  - After release: 0x5 is presented.
- **Async reset and saturation.** Assert reset mid-FULL between clock edges.
  - Required: outputs go to their reset values immediately, without waiting for an edge.
  - With CNT_W = 3, stall for 10 cycles. Required: stall_cnt saturates at 7.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with a two-entry skid buffer, synchronous flush
// to a programmable bubble value, external hold and a saturating stall counter.
module pipe_stage_skid #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              hold,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_data, main_data_nxt;
    logic [DATA_W-1:0] skid_data, skid_data_nxt;
    logic              main_valid, skid_valid;
    logic              in_fire, out_fire;

    assign main_valid = state[0];
    assign skid_valid = state[1];

    // Handshake outputs come only from registers and hold, never from out_ready.
    assign in_ready  = ~skid_valid & ~hold;
    assign out_valid = main_valid & ~hold;
    assign out_data  = main_valid ? main_data : FLUSH_VAL;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        state_nxt     = state;
        main_data_nxt = main_data;
        skid_data_nxt = skid_data;
        if (flush) begin
            state_nxt     = EMPTY;
            main_data_nxt = FLUSH_VAL;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt     = ONE;
                        main_data_nxt = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_nxt = in_data;
                    end else if (in_fire) begin
                        state_nxt     = FULL;
                        skid_data_nxt = in_data;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_nxt     = ONE;
                        main_data_nxt = skid_data;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            // NOTE: the data registers are reset too, so out_data is defined right after reset.
            main_data <= FLUSH_VAL;
            skid_data <= '0;
        end else begin
            state     <= state_nxt;
            main_data <= main_data_nxt;
            skid_data <= skid_data_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && !hold && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid: streaming, back-pressure, flush,
// hold, asynchronous reset and stall counter saturation.
module tb_pipe_stage_skid;

    localparam int                DATA_W    = 16;
    localparam logic [DATA_W-1:0] FLUSH_VAL = 16'hF00D;
    localparam int                CNT_W     = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic              hold;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(
        .DATA_W   (DATA_W),
        .FLUSH_VAL(FLUSH_VAL),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .flush    (flush),
        .hold     (hold),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        hold      = 1'b0;

        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'(FLUSH_VAL));
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Streaming
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = DATA_W'(i);
            tick();
            check("stream_data", 32'(out_data), 32'(i));
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_occ", 32'(occupancy), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_valid", 32'(out_valid), 32'd0);
        check("stream_drain_occ", 32'(occupancy), 32'd0);
        check("stream_stall", 32'(stall_cnt), 32'd0);

        // Back-pressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h000A;
        tick();
        check("bp_a_data", 32'(out_data), 32'hA);
        check("bp_a_occ", 32'(occupancy), 32'd1);
        check("bp_a_stall", 32'(stall_cnt), 32'd0);
        in_data = 16'h000B;
        tick();
        check("bp_b_occ", 32'(occupancy), 32'd2);
        check("bp_b_ready", 32'(in_ready), 32'd0);
        check("bp_b_data", 32'(out_data), 32'hA);
        check("bp_b_stall", 32'(stall_cnt), 32'd1);
        in_data = 16'h000C;
        tick();
        check("bp_c_ready", 32'(in_ready), 32'd0);
        check("bp_c_occ", 32'(occupancy), 32'd2);
        check("bp_c_data", 32'(out_data), 32'hA);
        check("bp_c_stall", 32'(stall_cnt), 32'd2);
        out_ready = 1'b1;
        #1;
        check("bp_rel_a", 32'(out_data), 32'hA);
        check("bp_rel_a_valid", 32'(out_valid), 32'd1);
        tick();
        check("bp_rel_b", 32'(out_data), 32'hB);
        check("bp_rel_b_valid", 32'(out_valid), 32'd1);
        check("bp_rel_b_ready", 32'(in_ready), 32'd1);
        check("bp_rel_b_occ", 32'(occupancy), 32'd1);
        tick();
        check("bp_rel_c", 32'(out_data), 32'hC);
        check("bp_rel_c_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        check("bp_drain_valid", 32'(out_valid), 32'd0);
        check("bp_drain_stall", 32'(stall_cnt), 32'd2);

        // Flush from FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0011;
        tick();
        in_data = 16'h0022;
        tick();
        check("fl_full_occ", 32'(occupancy), 32'd2);
        check("fl_full_stall", 32'(stall_cnt), 32'd3);
        in_data = 16'h0033;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_occ", 32'(occupancy), 32'd0);
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_data", 32'(out_data), 32'(FLUSH_VAL));
        check("fl_stall_kept", 32'(stall_cnt), 32'd4);
        out_ready = 1'b1;
        tick();
        check("fl_no_beat", 32'(out_valid), 32'd0);

        // Flush from ONE discards a beat accepted in the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0044;
        tick();
        in_data = 16'h0055;
        flush   = 1'b1;
        #1;
        check("fl1_accepting", 32'(in_ready), 32'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl1_occ", 32'(occupancy), 32'd0);
        check("fl1_data", 32'(out_data), 32'(FLUSH_VAL));
        check("fl1_stall", 32'(stall_cnt), 32'd5);
        out_ready = 1'b1;
        tick();
        check("fl1_no_beat", 32'(out_valid), 32'd0);

        // Flush together with hold
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0066;
        tick();
        in_data = 16'h0077;
        tick();
        check("flh_full_occ", 32'(occupancy), 32'd2);
        hold    = 1'b1;
        flush   = 1'b1;
        in_data = 16'h0088;
        tick();
        hold     = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flh_occ", 32'(occupancy), 32'd0);
        check("flh_valid", 32'(out_valid), 32'd0);
        check("flh_data", 32'(out_data), 32'(FLUSH_VAL));
        check("flh_stall", 32'(stall_cnt), 32'd6);

        // Pulse reset between edges to clear the counter
        reset = 1'b1;
        #2;
        reset = 1'b0;
        check("rst2_stall", 32'(stall_cnt), 32'd0);

        // Hold
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0005;
        tick();
        check("hold_one_data", 32'(out_data), 32'h5);
        hold    = 1'b1;
        in_data = 16'h0009;
        #1;
        check("hold_ready", 32'(in_ready), 32'd0);
        check("hold_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_cyc_ready", 32'(in_ready), 32'd0);
            check("hold_cyc_valid", 32'(out_valid), 32'd0);
            check("hold_cyc_occ", 32'(occupancy), 32'd1);
            check("hold_cyc_data", 32'(out_data), 32'h5);
            check("hold_cyc_stall", 32'(stall_cnt), 32'd0);
        end
        hold      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("hold_rel_valid", 32'(out_valid), 32'd1);
        check("hold_rel_data", 32'(out_data), 32'h5);
        tick();
        check("hold_rel_occ", 32'(occupancy), 32'd0);

        // Saturation, then asynchronous reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h00A1;
        tick();
        in_data = 16'h00A2;
        tick();
        in_valid = 1'b0;
        check("sat_start", 32'(stall_cnt), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("sat_mid", 32'(stall_cnt), 32'd6);
        for (int i = 0; i < 4; i++) tick();
        check("sat_max", 32'(stall_cnt), 32'd7);
        check("sat_occ", 32'(occupancy), 32'd2);
        check("sat_data", 32'(out_data), 32'hA1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_occ", 32'(occupancy), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'(FLUSH_VAL));
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_stall", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h00B1;
        out_ready = 1'b1;
        tick();
        check("arst_first_data", 32'(out_data), 32'hB1);
        check("arst_first_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        check("arst_drain_occ", 32'(occupancy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
